// File: rtl/spi_mem_arbiter.sv
// Two-port (fetch / data) sequencer in front of spi_master.
// Keeps sequential fetches in one open chip-select stream and closes it for anything else.
module spi_mem_arbiter #(
  parameter logic [7:0] READ_CMD       = 8'h03,
  parameter logic [7:0] WRITE_CMD      = 8'h02,
  parameter logic [5:0] DATA_LEN       = 6'd32,
  parameter int         CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  input  logic [23:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [23:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        m_start,
  output logic        m_stop,
  output logic        m_cont,
  output logic        m_write_enable,
  output logic        m_is_instr,
  output logic [31:0] m_cmd_addr,
  output logic [5:0]  m_data_len,
  output logic [31:0] m_data_in,
  input  logic [31:0] m_data_out,
  input  logic        m_done
);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    BUSY,
    STOP,
    GAP
  } state_t;

  localparam logic [3:0] GAP_INIT = 4'(CS_HIGH_CYCLES - 1);

  state_t      state;
  logic        m_done_q;
  logic        last_instr;
  logic [23:0] next_addr;
  logic [3:0]  gap_cnt;

  logic instr_pend;
  logic data_pend;
  logic grant_instr;
  logic grant_data;
  logic idle_arb;
  logic seq_fetch;
  logic done_rise;

  // A port whose ready is pulsing this cycle is still holding its old request; mask it.
  always_comb begin
    instr_pend  = instr_req & ~instr_ready;
    data_pend   = data_req & ~data_ready;
    grant_data  = data_pend & (~instr_pend | last_instr);
    grant_instr = instr_pend & ~grant_data;
    idle_arb    = (state == IDLE) || ((state == GAP) && (gap_cnt == 4'd0));
    seq_fetch   = grant_instr && (instr_addr == next_addr);
    done_rise   = m_done & ~m_done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      m_done_q       <= 1'b0;
      last_instr     <= 1'b1;
      next_addr      <= 24'd0;
      gap_cnt        <= 4'd0;
      instr_rdata    <= 32'd0;
      instr_ready    <= 1'b0;
      data_rdata     <= 32'd0;
      data_ready     <= 1'b0;
      m_start        <= 1'b0;
      m_stop         <= 1'b0;
      m_cont         <= 1'b0;
      m_write_enable <= 1'b0;
      m_is_instr     <= 1'b0;
      m_cmd_addr     <= 32'd0;
      m_data_len     <= 6'd0;
      m_data_in      <= 32'd0;
    end else begin
      m_start     <= 1'b0;
      m_stop      <= 1'b0;
      m_cont      <= 1'b0;
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      m_done_q    <= m_done;
      m_data_len  <= DATA_LEN;

      case (state)
        // The final GAP cycle arbitrates like IDLE so a held request starts without delay.
        IDLE, GAP: begin
          if (idle_arb && (grant_instr || grant_data)) begin
            m_start    <= 1'b1;
            state      <= BUSY;
            last_instr <= grant_instr;
            m_is_instr <= grant_instr;
            if (grant_instr) begin
              m_cmd_addr     <= {READ_CMD, instr_addr};
              m_write_enable <= 1'b0;
              m_data_in      <= 32'd0;
            end else begin
              m_cmd_addr     <= {(data_we ? WRITE_CMD : READ_CMD), data_addr};
              m_write_enable <= data_we;
              m_data_in      <= data_we ? data_wdata : 32'd0;
            end
          end else if (state == GAP) begin
            if (gap_cnt == 4'd0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
        end

        STREAM: begin
          if (seq_fetch) begin
            m_cont         <= 1'b1;
            m_cmd_addr     <= {READ_CMD, instr_addr};
            m_is_instr     <= 1'b1;
            m_write_enable <= 1'b0;
            m_data_in      <= 32'd0;
            last_instr     <= 1'b1;
            state          <= BUSY;
          end else if (grant_instr || grant_data) begin
            m_stop <= 1'b1;
            state  <= STOP;
          end
        end

        BUSY: begin
          if (done_rise) begin
            if (m_is_instr) begin
              instr_rdata <= m_data_out;
              instr_ready <= 1'b1;
              next_addr   <= m_cmd_addr[23:0] + 24'd4;
              state       <= STREAM;
            end else begin
              data_rdata <= m_data_out;
              data_ready <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        STOP: begin
          gap_cnt <= GAP_INIT;
          state   <= GAP;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: directed table, corner sequences and
// randomized single transactions predicted by a transaction-level stream model.
module tb_spi_mem_arbiter;

  localparam logic [7:0] READ_CMD  = 8'h03;
  localparam logic [7:0] WRITE_CMD = 8'h02;
  localparam logic [5:0] DATA_LEN  = 6'd32;
  localparam int         CS_HIGH   = 2;

  logic        clk;
  logic        rst_n;
  logic        instr_req;
  logic [23:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_ready;
  logic        data_req;
  logic        data_we;
  logic [23:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        m_start;
  logic        m_stop;
  logic        m_cont;
  logic        m_write_enable;
  logic        m_is_instr;
  logic [31:0] m_cmd_addr;
  logic [5:0]  m_data_len;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;
  logic        m_done;

  int tests;
  int fails;
  int overlap;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic        exp_cont;
    logic        exp_stop;
    logic [31:0] exp_cmd;
  } exp_t;

  typedef struct {
    bit          got;
    int          starts, conts, stops, first_cyc, stop_cyc, pulse_cyc;
    int          done_cyc, ready_cyc, readys, other, extra;
    logic [31:0] cmd, cmd_done, din, rdata;
    logic        we, is_instr;
    logic [5:0]  len;
  } obs_t;

  typedef struct {
    bit          done;
    int          np, stops, ri, rd;
    logic        p0_start, p0_instr, p1_start, p1_instr;
    logic [31:0] irdata, drdata;
  } both_t;

  // Transaction-level model: is a stream open, and which fetch address would continue it.
  bit          mdl_open;
  logic [23:0] mdl_next;
  bit          mdl_last_instr;

  spi_mem_arbiter #(
    .READ_CMD(READ_CMD),
    .WRITE_CMD(WRITE_CMD),
    .DATA_LEN(DATA_LEN),
    .CS_HIGH_CYCLES(CS_HIGH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_req(instr_req),
    .instr_addr(instr_addr),
    .instr_rdata(instr_rdata),
    .instr_ready(instr_ready),
    .data_req(data_req),
    .data_we(data_we),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_ready(data_ready),
    .m_start(m_start),
    .m_stop(m_stop),
    .m_cont(m_cont),
    .m_write_enable(m_write_enable),
    .m_is_instr(m_is_instr),
    .m_cmd_addr(m_cmd_addr),
    .m_data_len(m_data_len),
    .m_data_in(m_data_in),
    .m_data_out(m_data_out),
    .m_done(m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ((int'(m_start) + int'(m_stop) + int'(m_cont)) > 1)) overlap++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    mdl_open       = 1'b0;
    mdl_next       = 24'd0;
    mdl_last_instr = 1'b1;
  endfunction

  function automatic exp_t predict(input logic is_data, input logic we, input logic [23:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] mdata);
    exp_t e;
    e.is_data  = is_data;
    e.we       = we;
    e.addr     = addr;
    e.wdata    = wdata;
    e.mdata    = mdata;
    e.exp_cont = !is_data && mdl_open && (addr == mdl_next);
    e.exp_stop = mdl_open && !e.exp_cont;
    e.exp_cmd  = {((is_data && we) ? WRITE_CMD : READ_CMD), addr};
    return e;
  endfunction

  function automatic void serve(input exp_t e);
    if (e.is_data) begin
      mdl_open = 1'b0;
    end else begin
      mdl_open = 1'b1;
      mdl_next = e.addr + 24'd4;
    end
    mdl_last_instr = !e.is_data;
  endfunction

  task automatic doReset();
    rst_n      = 1'b0;
    instr_req  = 1'b0;
    instr_addr = 24'd0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = 24'd0;
    data_wdata = 32'd0;
    m_done     = 1'b0;
    m_data_out = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
  endtask

  task automatic checkResetOutputs(input string p);
    checkOutput({p, "_flags"}, 32'({m_start, m_stop, m_cont, instr_ready, data_ready,
                                    m_write_enable, m_is_instr}), 32'd0);
    checkOutput({p, "_cmd_addr"}, m_cmd_addr, 32'd0);
    checkOutput({p, "_instr_rdata"}, instr_rdata, 32'd0);
    checkOutput({p, "_data_rdata"}, data_rdata, 32'd0);
    checkOutput({p, "_data_in"}, m_data_in, 32'd0);
    checkOutput({p, "_data_len"}, 32'(m_data_len), 32'd0);
  endtask

  // One request on one port, with a master model answering after lat cycles, m_done held hold cycles.
  task automatic applyStimulus(input exp_t e, input int lat, input int hold, output obs_t o);
    int   resp;
    int   dleft;
    logic own;
    logic oth;
    o     = '{default: 0};
    resp  = -1;
    dleft = 0;
    if (e.is_data) begin
      data_req   = 1'b1;
      data_we    = e.we;
      data_addr  = e.addr;
      data_wdata = e.wdata;
    end else begin
      instr_req  = 1'b1;
      instr_addr = e.addr;
    end
    for (int cyc = 1; cyc <= 300 && !o.got; cyc++) begin
      @(posedge clk);
      #1;
      if ((m_start || m_cont || m_stop) && o.first_cyc == 0) o.first_cyc = cyc;
      if (m_stop) begin
        o.stops++;
        o.stop_cyc = cyc;
      end
      own = e.is_data ? data_ready : instr_ready;
      oth = e.is_data ? instr_ready : data_ready;
      if (oth) o.other++;
      if (own) begin
        o.readys++;
        o.ready_cyc = cyc;
        o.rdata     = e.is_data ? data_rdata : instr_rdata;
        o.got       = 1'b1;
      end
      if (m_done) begin
        if (dleft > 0) dleft--;
        else begin
          m_done     = 1'b0;
          m_data_out = ~e.mdata;
        end
      end
      if (resp > 0) begin
        resp--;
        if (resp == 0) begin
          m_done     = 1'b1;
          m_data_out = e.mdata;
          dleft      = hold - 1;
          o.done_cyc = cyc;
          o.cmd_done = m_cmd_addr;
          resp       = -1;
        end
      end
      if (m_start || m_cont) begin
        if (m_start) o.starts++;
        else o.conts++;
        o.pulse_cyc = cyc;
        o.cmd       = m_cmd_addr;
        o.din       = m_data_in;
        o.we        = m_write_enable;
        o.is_instr  = m_is_instr;
        o.len       = m_data_len;
        resp        = lat;
      end
    end
    if (o.got) begin
      @(posedge clk);
      #1;
      if (m_start || m_cont || m_stop) o.extra++;
      if (e.is_data ? data_ready : instr_ready) o.readys++;
      if (e.is_data ? instr_ready : data_ready) o.other++;
    end
    instr_req  = 1'b0;
    data_req   = 1'b0;
    m_done     = 1'b0;
    m_data_out = ~e.mdata;
  endtask

  task automatic checkOp(input int idx, input exp_t e, input obs_t o);
    string p;
    p = $sformatf("op%0d", idx);
    checkOutput({p, "_completed"}, 32'(o.got), 32'd1);
    checkOutput({p, "_starts"}, o.starts, e.exp_cont ? 0 : 1);
    checkOutput({p, "_conts"}, o.conts, e.exp_cont ? 1 : 0);
    checkOutput({p, "_stops"}, o.stops, e.exp_stop ? 1 : 0);
    checkOutput({p, "_first_pulse_cycle"}, o.first_cyc, 1);
    if (e.exp_stop) checkOutput({p, "_cs_high_gap"}, o.pulse_cyc - o.stop_cyc - 1, CS_HIGH);
    checkOutput({p, "_cmd_addr"}, o.cmd, e.exp_cmd);
    checkOutput({p, "_cmd_addr_held"}, o.cmd_done, e.exp_cmd);
    checkOutput({p, "_is_instr"}, 32'(o.is_instr), 32'(!e.is_data));
    checkOutput({p, "_write_enable"}, 32'(o.we), 32'(e.is_data && e.we));
    if (e.is_data && e.we) checkOutput({p, "_data_in"}, o.din, e.wdata);
    checkOutput({p, "_data_len"}, 32'(o.len), 32'(DATA_LEN));
    checkOutput({p, "_ready_count"}, o.readys, 1);
    checkOutput({p, "_other_ready"}, o.other, 0);
    checkOutput({p, "_stray_pulse"}, o.extra, 0);
    checkOutput({p, "_ready_latency"}, o.ready_cyc - o.done_cyc, 1);
    checkOutput({p, "_rdata"}, o.rdata, e.mdata);
  endtask

  // Both ports request together; each is dropped the cycle after its ready.
  task automatic applyBoth(input logic [23:0] ia, input logic [31:0] imd, input logic [23:0] da,
                           input logic dwe, input logic [31:0] dwd, input logic [31:0] dmd,
                           output both_t b);
    int          resp;
    bit          drop_i;
    bit          drop_d;
    bit          pulse;
    logic [31:0] cur_md;
    b          = '{default: 0};
    resp       = -1;
    drop_i     = 1'b0;
    drop_d     = 1'b0;
    cur_md     = 32'd0;
    instr_req  = 1'b1;
    instr_addr = ia;
    data_req   = 1'b1;
    data_we    = dwe;
    data_addr  = da;
    data_wdata = dwd;
    for (int cyc = 0; cyc < 400 && !b.done; cyc++) begin
      @(posedge clk);
      #1;
      if (m_stop) b.stops++;
      pulse = m_start || m_cont;
      if (pulse) begin
        if (b.np == 0) begin
          b.p0_start = m_start;
          b.p0_instr = m_is_instr;
        end else if (b.np == 1) begin
          b.p1_start = m_start;
          b.p1_instr = m_is_instr;
        end
        b.np++;
        cur_md = m_is_instr ? imd : dmd;
      end
      if (drop_i) instr_req = 1'b0;
      if (drop_d) data_req = 1'b0;
      if (instr_ready) begin
        b.ri++;
        b.irdata = instr_rdata;
        drop_i   = 1'b1;
      end
      if (data_ready) begin
        b.rd++;
        b.drdata = data_rdata;
        drop_d   = 1'b1;
      end
      if (m_done) begin
        m_done     = 1'b0;
        m_data_out = 32'h0BAD_0BAD;
      end
      if (resp > 0) begin
        resp--;
        if (resp == 0) begin
          m_done     = 1'b1;
          m_data_out = cur_md;
          resp       = -1;
        end
      end
      if (pulse) resp = 2;
      b.done = (b.ri > 0) && (b.rd > 0) && !instr_req && !data_req;
    end
    instr_req = 1'b0;
    data_req  = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic checkBoth(input string p, input both_t b, input int exp_stops,
                           input logic [31:0] imd, input logic [31:0] dmd);
    checkOutput({p, "_completed"}, 32'(b.done), 32'd1);
    checkOutput({p, "_stops"}, b.stops, exp_stops);
    checkOutput({p, "_grants"}, b.np, 2);
    checkOutput({p, "_first_is_start"}, 32'(b.p0_start), 32'd1);
    checkOutput({p, "_first_is_data"}, 32'(b.p0_instr), 32'd0);
    checkOutput({p, "_second_is_start"}, 32'(b.p1_start), 32'd1);
    checkOutput({p, "_second_is_instr"}, 32'(b.p1_instr), 32'd1);
    checkOutput({p, "_instr_readys"}, b.ri, 1);
    checkOutput({p, "_data_readys"}, b.rd, 1);
    checkOutput({p, "_instr_rdata"}, b.irdata, imd);
    checkOutput({p, "_data_rdata"}, b.drdata, dmd);
  endtask

  initial begin
    exp_t        vec[9];
    exp_t        e;
    obs_t        o;
    both_t       b;
    logic [31:0] rv;
    logic [31:0] rd;
    int          sel;
    int          seen;
    int          cnt;

    tests   = 0;
    fails   = 0;
    overlap = 0;

    vec[0] = '{1'b0, 1'b0, 24'h000100, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'h03000100};
    vec[1] = '{1'b0, 1'b0, 24'h000104, 32'h0,        32'hA5A5_0104, 1'b1, 1'b0, 32'h03000104};
    vec[2] = '{1'b0, 1'b0, 24'h000200, 32'h0,        32'h0000_0200, 1'b0, 1'b1, 32'h03000200};
    vec[3] = '{1'b1, 1'b1, 24'h001000, 32'hDEADBEEF, 32'h0000_1000, 1'b0, 1'b1, 32'h02001000};
    vec[4] = '{1'b0, 1'b0, 24'h000108, 32'h0,        32'h1111_0108, 1'b0, 1'b0, 32'h03000108};
    vec[5] = '{1'b1, 1'b0, 24'h002000, 32'h0,        32'h2222_2000, 1'b0, 1'b1, 32'h03002000};
    vec[6] = '{1'b0, 1'b0, 24'hFFFFFC, 32'h0,        32'hFFFF_FFFC, 1'b0, 1'b0, 32'h03FFFFFC};
    vec[7] = '{1'b0, 1'b0, 24'h000000, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 32'h03000000};
    vec[8] = '{1'b0, 1'b0, 24'h000004, 32'h0,        32'h4444_0004, 1'b1, 1'b0, 32'h03000004};

    rst_n      = 1'b1;
    instr_req  = 1'b0;
    instr_addr = 24'd0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = 24'd0;
    data_wdata = 32'd0;
    m_done     = 1'b0;
    m_data_out = 32'd0;
    #3 rst_n = 1'b0;
    #1;
    checkResetOutputs("reset");
    doReset();
    checkOutput("reset_data_len_after", 32'(m_data_len), 32'(DATA_LEN));

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vec[i], 2, 2, o);
      checkOp(i, vec[i], o);
      serve(vec[i]);
    end

    // Reset while a continued fetch is in flight: no ready, and the stream must be gone.
    e = predict(1'b0, 1'b0, 24'h000100, 32'h0, 32'h5555_0100);
    applyStimulus(e, 2, 1, o);
    checkOp(50, e, o);
    serve(e);
    instr_req  = 1'b1;
    instr_addr = 24'h000104;
    seen       = 0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      @(posedge clk);
      #1;
      if (m_cont) seen = 1;
    end
    checkOutput("midrst_cont_seen", seen, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    instr_req = 1'b0;
    rst_n     = 1'b1;
    cnt       = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      #1;
      if (instr_ready || data_ready || m_start || m_cont || m_stop) cnt++;
    end
    checkOutput("midrst_no_activity", cnt, 0);
    modelReset();
    e = predict(1'b0, 1'b0, 24'h000104, 32'h0, 32'h6666_0104);
    applyStimulus(e, 3, 1, o);
    checkOp(51, e, o);
    serve(e);

    // Simultaneous requests from reset, then again with a stream open.
    doReset();
    applyBoth(24'h000300, 32'h7777_0300, 24'h003000, 1'b0, 32'h0, 32'h8888_3000, b);
    checkBoth("both1", b, 0, 32'h7777_0300, 32'h8888_3000);
    applyBoth(24'h000304, 32'h7777_0304, 24'h003004, 1'b1, 32'hCAFEF00D, 32'h8888_3004, b);
    checkBoth("both2", b, 1, 32'h7777_0304, 32'h8888_3004);
    mdl_open       = 1'b1;
    mdl_next       = 24'h000308;
    mdl_last_instr = 1'b1;

    for (int i = 0; i < 60; i++) begin
      rv  = $urandom();
      rd  = $urandom();
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        e = predict(1'b0, 1'b0, mdl_open ? mdl_next : {rv[23:2], 2'b00}, 32'h0, rd);
      end else if (sel <= 5) begin
        e = predict(1'b0, 1'b0, {rv[23:2], 2'b00}, 32'h0, rd);
      end else if (sel == 6) begin
        e = predict(1'b0, 1'b0, 24'hFFFFFC, 32'h0, rd);
      end else begin
        e = predict(1'b1, rv[31], rv[23:0], $urandom(), rd);
      end
      applyStimulus(e, $urandom_range(1, 4), $urandom_range(1, 3), o);
      checkOp(100 + i, e, o);
      serve(e);
    end

    checkOutput("pulse_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
